// File: rtl/vga_pkg.sv
// Shared VGA plotting definitions: screen geometry, plotter states and
// the end-coordinate clipping helper used when a rectangle is accepted.
package vga_pkg;

  localparam int X_W   = 8;
  localparam int Y_W   = 7;
  localparam int C_W   = 3;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;

  // Width used for end-coordinate arithmetic; wide enough for x0+w-1.
  localparam int CLIP_W = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2,
    FIN   = 2'd3
  } plot_state_t;

  typedef struct packed {
    logic [CLIP_W-1:0] end_c;
    logic              empty;
  } clip_t;

  // Last covered coordinate of a span starting at start_c with len_c
  // pixels, limited to max_c. A zero-length span or one starting beyond
  // max_c is flagged empty (end_c is then meaningless).
  function automatic clip_t clip_end(input logic [CLIP_W-1:0] start_c,
                                     input logic [CLIP_W-1:0] len_c,
                                     input logic [CLIP_W-1:0] max_c);
    clip_t           res;
    logic [CLIP_W:0] sum;
    sum       = {1'b0, start_c} + {1'b0, len_c} - {{CLIP_W{1'b0}}, 1'b1};
    res.empty = (len_c == {CLIP_W{1'b0}}) || (start_c > max_c);
    if (sum > {1'b0, max_c}) begin
      res.end_c = max_c;
    end else begin
      res.end_c = sum[CLIP_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rect_plotter.sv
// Filled-rectangle / clear-screen command engine for the VGA plot port.
// Emits one pixel per clock in row-major order, clipped to the screen.
module rect_plotter
  import vga_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           start,
  input  logic           clear,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  input  logic [C_W-1:0] colour_in,
  output logic           busy,
  output logic           done,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           vga_resetn
);

  plot_state_t       state_r, state_s;
  logic [X_W-1:0]    x_r, x_s;
  logic [Y_W-1:0]    y_r, y_s;
  logic [C_W-1:0]    colour_r, colour_s;
  logic              plot_r, plot_s;
  logic              vga_resetn_r, vga_resetn_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [X_W-1:0]    x0_r, x0_s;
  logic [CLIP_W-1:0] xe_r, xe_s;
  logic [CLIP_W-1:0] ye_r, ye_s;
  clip_t             clip_x_s, clip_y_s;
  logic              last_col_s, last_row_s;

  // Clipped end coordinates of the rectangle currently on the inputs.
  always_comb begin
    clip_x_s = clip_end({1'b0, x0}, {1'b0, w}, CLIP_W'(X_MAX));
    clip_y_s = clip_end({2'b00, y0}, {2'b00, h}, CLIP_W'(Y_MAX));
  end

  // Scan position compared against the latched rectangle corner.
  always_comb begin
    last_col_s = ({1'b0, x_r} == xe_r);
    last_row_s = ({2'b00, y_r} == ye_r);
  end

  // Next-state and next-output logic; pixel position lives in x_r/y_r.
  always_comb begin
    state_s      = state_r;
    x_s          = x_r;
    y_s          = y_r;
    colour_s     = colour_r;
    plot_s       = 1'b0;
    vga_resetn_s = 1'b1;
    busy_s       = 1'b0;
    done_s       = 1'b0;
    x0_s         = x0_r;
    xe_s         = xe_r;
    ye_s         = ye_r;
    case (state_r)
      IDLE, FIN: begin
        // FIN accepts a new command just like IDLE for back-to-back use.
        if (clear) begin
          state_s      = CLEAR;
          vga_resetn_s = 1'b0;
          busy_s       = 1'b1;
        end else if (start) begin
          if (clip_x_s.empty || clip_y_s.empty) begin
            state_s = FIN;
            done_s  = 1'b1;
          end else begin
            state_s  = DRAW;
            x_s      = x0;
            y_s      = y0;
            colour_s = colour_in;
            x0_s     = x0;
            xe_s     = clip_x_s.end_c;
            ye_s     = clip_y_s.end_c;
            plot_s   = 1'b1;
            busy_s   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      DRAW: begin
        if (last_col_s && last_row_s) begin
          state_s = FIN;
          done_s  = 1'b1;
        end else if (last_col_s) begin
          x_s    = x0_r;
          y_s    = y_r + 7'd1;
          plot_s = 1'b1;
          busy_s = 1'b1;
        end else begin
          x_s    = x_r + 8'd1;
          plot_s = 1'b1;
          busy_s = 1'b1;
        end
      end
      CLEAR: begin
        state_s = FIN;
        done_s  = 1'b1;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r      <= IDLE;
      x_r          <= 8'd0;
      y_r          <= 7'd0;
      colour_r     <= 3'd0;
      plot_r       <= 1'b0;
      vga_resetn_r <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      x0_r         <= 8'd0;
      xe_r         <= 9'd0;
      ye_r         <= 9'd0;
    end else begin
      state_r      <= state_s;
      x_r          <= x_s;
      y_r          <= y_s;
      colour_r     <= colour_s;
      plot_r       <= plot_s;
      vga_resetn_r <= vga_resetn_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      x0_r         <= x0_s;
      xe_r         <= xe_s;
      ye_r         <= ye_s;
    end
  end

  assign x          = x_r;
  assign y          = y_r;
  assign colour     = colour_r;
  assign plot       = plot_r;
  assign vga_resetn = vga_resetn_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed bench for rect_plotter: hand-computed pixel sequences,
// clipping, empty commands, clear priority, ignored requests and reset.
module tb_rect_plotter;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x0 = 8'd0;
  logic [6:0] y0 = 7'd0;
  logic [7:0] w = 8'd0;
  logic [6:0] h = 7'd0;
  logic [2:0] colour_in = 3'd0;
  logic       busy, done, plot, vga_resetn;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int total = 0;
  int bad = 0;

  int ex3[6] = '{0, 1, 2, 0, 1, 2};
  int ey3[6] = '{0, 0, 0, 1, 1, 1};
  int exc[4] = '{158, 159, 158, 159};
  int eyc[4] = '{118, 118, 119, 119};

  rect_plotter dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
    .busy      (busy),
    .done      (done),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .vga_resetn(vga_resetn)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pixel(input string tag, input int ex, input int ey, input int ec);
    check({tag, "_plot"}, 32'(plot), 32'd1);
    check({tag, "_x"}, 32'(x), 32'(ex));
    check({tag, "_y"}, 32'(y), 32'(ey));
    check({tag, "_col"}, 32'(colour), 32'(ec));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic finished(input string tag);
    check({tag, "_plot"}, 32'(plot), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic cmd(input int cx, input int cy, input int cw, input int ch, input int cc);
    x0 = 8'(cx); y0 = 7'(cy); w = 8'(cw); h = 7'(ch); colour_in = 3'(cc);
    start = 1'b1;
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_col", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_vgarn", 32'(vga_resetn), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    tick();

    // single pixel
    cmd(10, 20, 1, 1, 5);
    tick(); start = 1'b0;
    pixel("one", 10, 20, 5);
    tick();
    finished("one_fin");
    check("one_hold_x", 32'(x), 32'd10);
    check("one_hold_y", 32'(y), 32'd20);
    check("one_hold_c", 32'(colour), 32'd5);
    tick();
    check("one_idle_done", 32'(done), 32'd0);

    // 3x2 rectangle, followed back-to-back by a clipped one
    cmd(0, 0, 3, 2, 2);
    tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pixel($sformatf("r32_%0d", i), ex3[i], ey3[i], 2);
      tick();
    end
    finished("r32_fin");
    check("r32_hold_x", 32'(x), 32'd2);
    check("r32_hold_y", 32'(y), 32'd1);
    cmd(158, 118, 5, 5, 6);
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pixel($sformatf("clip_%0d", i), exc[i], eyc[i], 6);
      tick();
    end
    finished("clip_fin");
    tick();

    // empty: x0 beyond screen
    cmd(200, 5, 5, 5, 1);
    tick(); start = 1'b0;
    finished("empty_x");
    tick();
    check("empty_x_after", 32'(plot) + 32'(done) + 32'(busy), 32'd0);

    // empty: zero width
    cmd(5, 5, 0, 5, 1);
    tick(); start = 1'b0;
    finished("empty_w");
    tick();

    // clear wins over start
    cmd(1, 1, 4, 4, 3);
    clear = 1'b1;
    tick(); start = 1'b0; clear = 1'b0;
    check("clr_vgarn", 32'(vga_resetn), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_plot", 32'(plot), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    tick();
    check("clr_vgarn2", 32'(vga_resetn), 32'd1);
    finished("clr_fin");
    tick();

    // request while busy is ignored
    cmd(30, 40, 2, 2, 3);
    tick();
    pixel("ign_0", 30, 40, 3);
    cmd(0, 0, 10, 10, 7);
    tick(); start = 1'b0;
    pixel("ign_1", 31, 40, 3);
    tick();
    pixel("ign_2", 30, 41, 3);
    tick();
    pixel("ign_3", 31, 41, 3);
    tick();
    finished("ign_fin");
    tick();
    check("ign_idle", 32'(plot) + 32'(done) + 32'(busy), 32'd0);

    // reset in the middle of a 10x10 draw
    cmd(0, 0, 10, 10, 1);
    tick(); start = 1'b0;
    pixel("mid_0", 0, 0, 1);
    tick();
    pixel("mid_1", 1, 0, 1);
    tick();
    pixel("mid_2", 2, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_x", 32'(x), 32'd0);
    check("mid_col", 32'(colour), 32'd0);
    check("mid_plot", 32'(plot), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    tick();
    check("mid_after", 32'(plot) + 32'(done) + 32'(busy), 32'd0);
    cmd(7, 8, 1, 1, 4);
    tick(); start = 1'b0;
    pixel("post", 7, 8, 4);
    tick();
    finished("post_fin");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
